// File: rtl/bcd_converter.sv
// Serial binary-to-BCD converter (double dabble), one input bit per clock, start/busy/done handshake.
// done pulses WIDTH cycles after the accepting edge; start is ignored while busy.
module bcd_converter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    shift_reg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] corrected;
  logic [4*DIGITS-1:0] next_scratch;
  logic [DIGITS-1:0]   next_blank;
  logic                all_zero;

  // Per-digit add-3 with no carry between digits, then shift in the next binary bit.
  always_comb begin
    corrected = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        corrected[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  assign next_scratch = {corrected[4*DIGITS-2:0], shift_reg[WIDTH-1]};

  // Leading-zero flags: walk down from the top digit; units digit is never blanked.
  always_comb begin
    next_blank = '0;
    all_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero & (next_scratch[4*k +: 4] == 4'd0);
      next_blank[k] = all_zero;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      blank     <= BLANK_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            count     <= CW'(WIDTH);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= next_scratch;
          shift_reg <= shift_reg << 1;
          count     <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd_out <= next_scratch;
            blank   <= next_blank;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: vector table, scoreboard of expected results, multi-cycle corner sequences.
module tb_bcd_converter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic [13:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blk;
  } vec_t;
  vec_t vecs[7];

  bcd_converter #(.WIDTH(14), .DIGITS(5)) dut (
    .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] b;
    int p;
    b = '0;
    p = 10;
    for (int k = 1; k < 5; k++) begin
      b[k] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bcd %h with no pending conversion, expected none", bcd_out);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e[24:5]));
        check("blank", 32'(blank), 32'(e[4:0]));
      end
    end
  end

  // Called while the clock is low; returns just after the accepting edge.
  task automatic start_conv(input logic [13:0] v, input logic [19:0] eb, input logic [4:0] ek);
    start  = 1'b1;
    bin_in = v;
    exp_q.push_back({eb, ek});
    acc_cnt++;
    @(posedge clock);
    #1;
    start  = 1'b0;
    bin_in = 14'($urandom);
  endtask

  // Returns on the negedge where done is seen; cyc counts busy-high cycles before it.
  task automatic wait_done(output int cyc);
    int n;
    cyc = 0;
    n = 0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) break;
      if (busy === 1'b1) cyc++;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected done within 14", n);
        break;
      end
    end
  endtask

  initial begin
    int cyc, dcount, n;
    logic [13:0] v;

    vecs[0] = '{14'd0,     20'h00000, 5'b11110};
    vecs[1] = '{14'd16383, 20'h16383, 5'b00000};
    vecs[2] = '{14'd1234,  20'h01234, 5'b10000};
    vecs[3] = '{14'd9,     20'h00009, 5'b11110};
    vecs[4] = '{14'd10,    20'h00010, 5'b11100};
    vecs[5] = '{14'd10000, 20'h10000, 5'b00000};
    vecs[6] = '{14'd999,   20'h00999, 5'b11000};

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_blank", 32'(blank), 32'b11110);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      start_conv(vecs[i].bin, vecs[i].bcd, vecs[i].blk);
      wait_done(cyc);
      check("busy_cycles", 32'(cyc), 32'd14);
    end

    // start re-pulsed mid-conversion must be ignored and not queued
    start_conv(14'd100, 20'h00100, 5'b11000);
    dcount = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (done === 1'b1) dcount++;
      start  = (c == 3 || c == 13);
      bin_in = 14'd77;
    end
    start = 1'b0;
    check("ignored_start_dones", 32'(dcount), 32'd1);

    // reset on busy cycle 7 aborts with no done
    start_conv(14'd59, 20'h00059, 5'b11100);
    for (int c = 1; c <= 7; c++) @(negedge clock);
    reset = 1'b1;
    void'(exp_q.pop_back());
    acc_cnt--;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'h0);
    check("abort_blank", 32'(blank), 32'b11110);
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    start_conv(14'd59, 20'h00059, 5'b11100);
    wait_done(cyc);

    // reset and start together: reset wins
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    bin_in = 14'd5;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("rst_start_busy", 32'(busy), 32'd0);

    // back-to-back: second start accepted in the done cycle
    start_conv(14'd4321, 20'h04321, 5'b10000);
    wait_done(cyc);
    start_conv(14'd8765, 20'h08765, 5'b10000);
    n = 1;
    forever begin
      @(negedge clock);
      if (done === 1'b1 || n > 40) break;
      n++;
      check("hold_between", 32'(bcd_out), 32'h04321);
    end
    check("b2b_period", 32'(n), 32'd15);

    // random sweep against the reference model
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      v = 14'($urandom_range(0, 16383));
      start_conv(v, ref_bcd(int'(v)), ref_blank(int'(v)));
      wait_done(cyc);
    end

    repeat (3) @(negedge clock);
    check("done_count", 32'(done_cnt), 32'(acc_cnt));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
